// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch-queue entry type for the LEGv8
// instruction-fetch sequencer (fetch_ctrl / fetch_queue).
package fetch_pkg;

    localparam int FETCH_N   = 32;
    localparam int FETCH_PCW = 64;

    // CBZ XZR,#0 -- an unconditional branch-to-self used as a stop marker.
    localparam logic [FETCH_N-1:0] HALT_INSTR  = 32'hb400001f;
    localparam logic [2:0]         INSTR_BYTES = 3'd4;

    typedef struct packed {
        logic [FETCH_N-1:0]   instr;
        logic [FETCH_PCW-1:0] pc;
    } fetch_entry_t;

    // True when a fetched word is the halt marker.
    function automatic logic is_halt(input logic [FETCH_N-1:0] word);
        return (word == HALT_INSTR);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous shift-register FIFO of fetch entries.
// The head always lives in entries_r[0], so the head outputs come straight
// from a register. Push and pop may coincide at any fill level, including
// full; flush empties the queue and wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    entries_r [DEPTH];
    logic [CW-1:0]   count_r;
    logic            do_pop_s;
    logic            do_push_s;
    logic [IW-1:0]   wr_idx_s;

    // Qualify push/pop against the fill level and pick the write slot.
    always_comb begin
        do_pop_s  = pop && (count_r != CW'(0));
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
        if (do_pop_s) begin
            wr_idx_s = IW'(count_r - CW'(1));
        end else begin
            wr_idx_s = IW'(count_r);
        end
    end

    // Entry storage and occupancy count; shift toward the head on pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else if (flush) begin
            count_r <= CW'(0);
        end else begin
            if (do_pop_s) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entries_r[i] <= entries_r[i+1];
                end
            end
            if (do_push_s) begin
                entries_r[wr_idx_s] <= push_data;
            end
            count_r <= count_r + (do_push_s ? CW'(1) : CW'(0))
                               - (do_pop_s  ? CW'(1) : CW'(0));
        end
    end

    assign head  = entries_r[0];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: LEGv8 instruction-fetch sequencer. Owns the PC, addresses the
// 2^AW-word instruction ROM, and buffers fetched words toward decode with a
// valid/ready handshake. Branch redirects flush the queue and reload the PC.
// Optional feature macro FETCH_HALT_EN: stop fetching after the halt word
// (CBZ XZR,#0) is enqueued, until redirect or reset. Without it, halted is 0.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int N     = 32,
    parameter int AW    = 6,
    parameter int PCW   = 64,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    output logic [AW-1:0]  imem_addr,
    input  logic [N-1:0]   imem_q,
    input  logic           redirect_valid,
    input  logic [PCW-1:0] redirect_pc,
    output logic           instr_valid,
    output logic [N-1:0]   instr,
    output logic [PCW-1:0] instr_pc,
    input  logic           instr_ready,
    output logic           halted
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [PCW-1:0] pc_r;
    logic           pop_s;
    logic           fetch_s;
    logic           halt_stop_s;
    fetch_entry_t   push_entry_s;
    fetch_entry_t   head_s;
    logic           q_full_s;
    logic           q_empty_s;
    logic [CW-1:0]  q_count_s;
    logic           unused_s;

`ifdef FETCH_HALT_EN
    logic halted_r;

    // Halt flag: set on the edge that enqueues the halt word, cleared by redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            halted_r <= 1'b0;
        end else if (redirect_valid) begin
            halted_r <= 1'b0;
        end else if (fetch_s && is_halt(imem_q)) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    assign halt_stop_s = halted_r;
    assign halted      = halted_r;
`else
    assign halt_stop_s = 1'b0;
    assign halted      = 1'b0;
`endif

    // Handshake and fetch decision; instr_valid never looks at instr_ready.
    always_comb begin
        pop_s   = instr_valid && instr_ready;
        fetch_s = 1'b0;
        if (halt_stop_s || redirect_valid) begin
            fetch_s = 1'b0;
        end else begin
            fetch_s = !q_full_s || pop_s;
        end
        push_entry_s.instr = imem_q;
        push_entry_s.pc    = pc_r;
    end

    // Program counter: redirect reloads word-aligned target, fetch advances.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r <= '0;
        end else if (redirect_valid) begin
            pc_r <= {redirect_pc[PCW-1:2], 2'b00};
        end else if (fetch_s) begin
            pc_r <= pc_r + PCW'(INSTR_BYTES);
        end else begin
            pc_r <= pc_r;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (fetch_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head      (head_s),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .count     (q_count_s)
    );

    // Upper PC bits simply alias onto the ROM; only the word index matters.
    assign imem_addr   = pc_r[AW+1:2];
    assign instr_valid = !q_empty_s;
    assign instr       = head_s.instr;
    assign instr_pc    = head_s.pc;

    // Target byte offset is ignored; occupancy is carried by empty/full.
    assign unused_s = ^{redirect_pc[1:0], q_count_s};

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized stimulus for fetch_ctrl,
// checked every cycle against a queue-based behavioural model of the fetch
// rules, with literal expectations pinning the key scenarios.
module tb_fetch_ctrl;

    localparam int MDEPTH = 2;
    localparam logic [31:0] HALT_W = 32'hb400001f;

    typedef struct {
        logic [31:0] w;
        logic [63:0] pc;
    } ent_t;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic        halted;

    logic [31:0] rom [64];
    ent_t        mq[$];
    logic [63:0] mpc;
    logic        mhalt;
    logic [63:0] delivered[$];
    logic        chk_en;
    int          total;
    int          bad;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .halted         (halted)
    );

    assign imem_q = rom[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one clock edge of the fetch rules.
    task automatic model_step();
        bit   pop;
        bit   fetch;
        ent_t e;
        if (!reset) begin
            mq.delete();
            mpc   = 64'd0;
            mhalt = 1'b0;
        end else begin
            pop = (mq.size() > 0) && instr_ready;
            if (pop) delivered.push_back(mq[0].pc);
            if (redirect_valid) begin
                mq.delete();
                mpc   = {redirect_pc[63:2], 2'b00};
                mhalt = 1'b0;
            end else begin
                fetch = !mhalt && ((mq.size() < MDEPTH) || pop);
                if (pop) void'(mq.pop_front());
                if (fetch) begin
                    e.w  = rom[(mpc / 64'd4) % 64'd64];
                    e.pc = mpc;
                    mq.push_back(e);
                    mpc = mpc + 64'd4;
`ifdef FETCH_HALT_EN
                    if (e.w == HALT_W) mhalt = 1'b1;
`endif
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: DUT state-derived outputs against the model each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("valid", {63'd0, instr_valid}, {63'd0, (mq.size() != 0)});
                if (mq.size() != 0) begin
                    chk("instr", {32'd0, instr}, {32'd0, mq[0].w});
                    chk("instr_pc", instr_pc, mq[0].pc);
                end
                chk("imem_addr", {58'd0, imem_addr}, {58'd0, mpc[7:2]});
                chk("halted", {63'd0, halted}, {63'd0, mhalt});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] deliv_at(input int idx);
        if (idx < delivered.size()) return delivered[idx];
        else return 64'hffff_ffff_ffff_ffff;
    endfunction

    initial begin
        int mark;
        int b8_cnt;
        total = 0;
        bad   = 0;
        chk_en = 1'b0;
        mpc = 64'd0;
        mhalt = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = $urandom;
            if (rom[i] == HALT_W) rom[i] = 32'h0;
        end
        rom[0]  = 32'hf8000001;
        rom[1]  = 32'hf8008002;
        rom[46] = HALT_W;
        reset = 1'b0;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;

        tick(2);
        chk_en = 1'b1;
        tick(1);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_addr", {58'd0, imem_addr}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);

        // Reset release, one instruction per cycle.
        reset = 1'b1;
        tick(1);
        chk("t1_instr0", {32'd0, instr}, 64'hf8000001);
        chk("t1_pc0", instr_pc, 64'd0);
        tick(1);
        chk("t1_instr1", {32'd0, instr}, 64'hf8008002);
        chk("t1_pc1", instr_pc, 64'd4);
        tick(1);
        chk("t1_pc2", instr_pc, 64'd8);

        // Back-pressure after reset.
        reset = 1'b0;
        instr_ready = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(5);
        chk("t2_addr", {58'd0, imem_addr}, 64'd2);
        chk("t2_instr", {32'd0, instr}, 64'hf8000001);
        chk("t2_pc", instr_pc, 64'd0);
        instr_ready = 1'b1;
        mark = delivered.size();
        tick(3);
        chk("t2_d0", deliv_at(mark), 64'd0);
        chk("t2_d1", deliv_at(mark + 1), 64'd4);
        chk("t2_d2", deliv_at(mark + 2), 64'd8);

        // Redirect with a full queue.
        instr_ready = 1'b0;
        tick(3);
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h74;
        tick(1);
        chk("t3_flush", {63'd0, instr_valid}, 64'd0);
        redirect_valid = 1'b0;
        mark = delivered.size();
        tick(1);
        chk("t3_pc", instr_pc, 64'h74);
        chk("t3_instr", {32'd0, instr}, {32'd0, rom[29]});
        tick(1);
        chk("t3_first", deliv_at(mark), 64'h74);

        // Unaligned target with upper bits above the ROM.
        redirect_valid = 1'b1;
        redirect_pc = 64'h103;
        tick(1);
        chk("t4_addr", {58'd0, imem_addr}, 64'd0);
        redirect_valid = 1'b0;
        tick(1);
        chk("t4_pc", instr_pc, 64'h100);
        chk("t4_instr", {32'd0, instr}, 64'hf8000001);

        // Halt word at 0xB8.
        redirect_valid = 1'b1;
        redirect_pc = 64'hb0;
        tick(1);
        redirect_valid = 1'b0;
        mark = delivered.size();
        tick(3);
`ifdef FETCH_HALT_EN
        chk("t5_halt", {63'd0, halted}, 64'd1);
`else
        chk("t5_halt", {63'd0, halted}, 64'd0);
`endif
        tick(3);
        b8_cnt = 0;
        for (int i = mark; i < delivered.size(); i++) begin
            if (delivered[i] == 64'hb8) b8_cnt++;
        end
        chk("t5_b8_once", 64'(b8_cnt), 64'd1);
`ifdef FETCH_HALT_EN
        chk("t5_last", deliv_at(delivered.size() - 1), 64'hb8);
        chk("t5_drained", {63'd0, instr_valid}, 64'd0);
`else
        chk("t5_last", deliv_at(delivered.size() - 1), 64'hc0);
        chk("t5_running", {63'd0, instr_valid}, 64'd1);
`endif
        redirect_valid = 1'b1;
        redirect_pc = 64'd0;
        tick(1);
        chk("t5_restart", {63'd0, halted}, 64'd0);
        redirect_valid = 1'b0;

        // Reset with full queue and redirect pending.
        instr_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        tick(1);
        chk("t6_valid", {63'd0, instr_valid}, 64'd0);
        chk("t6_addr", {58'd0, imem_addr}, 64'd0);
        chk("t6_halted", {63'd0, halted}, 64'd0);
        reset = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        tick(1);
        chk("t6_pc0", instr_pc, 64'd0);
        chk("t6_instr0", {32'd0, instr}, 64'hf8000001);

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 5);
            case ($urandom_range(0, 3))
                0: redirect_pc = {$urandom, $urandom};
                1: redirect_pc = 64'hffff_ffff_ffff_fff0 | 64'($urandom_range(0, 15));
                2: redirect_pc = 64'($urandom_range(0, 255));
                default: redirect_pc = 64'hb0;
            endcase
            reset = ($urandom_range(0, 199) != 0);
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
